// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
//   start, signed_op, dividend, divisor  : request side, driven by the master
//   quotient, remainder                   : registered results, driven by the slave
//   ready, busy, div_by_zero, overflow    : completion pulse and status, driven by the slave
interface seq_divider_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, ready, busy, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, ready, busy, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Fixed latency of WIDTH+1 edges from the accept edge, signed or unsigned operands.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, aborts any operation in flight
//   bus : seq_divider_if slave (start/operands in, quotient/remainder/ready/busy/flags out)
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StDivide, StFixup} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;       // partial remainder
    logic [WIDTH-1:0] quo;       // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dmag;      // divisor magnitude
    logic [WIDTH-1:0] dvd_raw;   // raw dividend, returned as remainder on divide-by-zero
    logic             neg_quo;
    logic             neg_rem;
    logic             dbz_pend;
    logic             ovf_pend;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             ready_r;
    logic             busy_r;
    logic             dbz_r;
    logic             ovf_r;

    // Operand magnitudes at accept; -MIN wraps to MIN, which read unsigned is 2^(WIDTH-1).
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    always_comb begin
        a_neg   = bus.signed_op & bus.dividend[WIDTH-1];
        b_neg   = bus.signed_op & bus.divisor[WIDTH-1];
        dvd_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        dvs_mag = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    end

    // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
    // The extra MSB on the subtract is the borrow; clear borrow means trial >= 0.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic             unused_trial_bit;

    always_comb begin
        shifted          = {rem, quo[WIDTH-1]};
        trial            = {1'b0, shifted} - {2'b00, dmag};
        trial_ok         = ~trial[WIDTH+1];
        // rem < dmag always holds, so the accepted trial fits in WIDTH bits.
        unused_trial_bit = trial[WIDTH];
    end

    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        quo_fix = neg_quo ? (~quo + 1'b1) : quo;
        rem_fix = neg_rem ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dmag        <= '0;
            dvd_raw     <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        rem      <= '0;
                        quo      <= dvd_mag;
                        dmag     <= dvs_mag;
                        dvd_raw  <= bus.dividend;
                        neg_quo  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        dbz_pend <= (bus.divisor == '0);
                        ovf_pend <= bus.signed_op && (bus.dividend == MinVal)
                                    && (bus.divisor == AllOnes);
                        count    <= '0;
                        busy_r   <= 1'b1;
                        dbz_r    <= 1'b0;
                        ovf_r    <= 1'b0;
                        state    <= StDivide;
                    end
                end
                StDivide: begin
                    if (trial_ok) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= StFixup;
                    end
                end
                StFixup: begin
                    if (dbz_pend) begin
                        quotient_r  <= AllOnes;
                        remainder_r <= dvd_raw;
                        dbz_r       <= 1'b1;
                        ovf_r       <= 1'b0;
                    end else if (ovf_pend) begin
                        quotient_r  <= MinVal;
                        remainder_r <= '0;
                        dbz_r       <= 1'b0;
                        ovf_r       <= 1'b1;
                    end else begin
                        quotient_r  <= quo_fix;
                        remainder_r <= rem_fix;
                        dbz_r       <= 1'b0;
                        ovf_r       <= 1'b0;
                    end
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.ready       = ready_r;
    assign bus.busy        = busy_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative radix-2 restoring divider. It is the inverse companion of the team's sequential Booth multiplier and shares the same start/ready handshake style. It produces one quotient bit per cycle and supports signed (two's complement) and unsigned operands. It sits beside the multiplier in the arithmetic datapath and is driven by the same top-level sequencer.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request; sampled only in IDLE
signed_op  input  1  1 = signed two's-complement operation, 0 = unsigned; captured with start
dividend  input  WIDTH  numerator; captured with start
divisor  input  WIDTH  denominator; captured with start
quotient  output  WIDTH  registered result, held until next completion
remainder  output  WIDTH  registered result, held until next completion
ready  output  1  one-cycle completion pulse
busy  output  1  high from accept edge until completion edge
div_by_zero  output  1  status for last result, valid with/after ready
overflow  output  1  status for last result (signed MIN / -1)

Behaviour:
- Reset (rst=1 at edge): state=IDLE, counter=0, all outputs 0. Reset mid-operation aborts; no ready is issued; start is accepted on the first edge after rst drops.
- States: IDLE, DIVIDE, FIXUP.
- IDLE: start=1 at edge E0 -> latch signed_op, sign bits, magnitudes |dividend| and |divisor| (unsigned WIDTH-bit; the magnitude of MIN is 2^(WIDTH-1), no widening), partial remainder=0, counter=0, busy<=1, go to DIVIDE. With start=0, stay in IDLE.
- DIVIDE: each edge shifts {rem,quo} left by 1 and computes trial = rem - divisor_mag using a WIDTH+1-bit subtract. If trial >= 0: rem=trial, quo[0]=1; else restore, quo[0]=0. The counter increments. After WIDTH steps (edges E1..E_WIDTH), go to FIXUP.
- FIXUP (edge E_WIDTH+1):
  - Signed: negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative. Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Result registers update, ready<=1, busy<=0, state<=IDLE.
- ready is high for exactly one cycle (E_WIDTH+1 to E_WIDTH+2). Fixed latency is WIDTH+1 edges from the accept edge, independent of operand values.
- start is ignored while busy. A start asserted in the ready cycle is accepted (back-to-back operation).
- Divide-by-zero: fixed latency is kept. Result forced to quotient = all ones, remainder = raw dividend, div_by_zero=1, overflow=0.
- Signed overflow (dividend = 100..0, divisor = all ones, signed_op=1): quotient = 100..0 (wrap), remainder = 0, overflow=1.
- Status flags update only at FIXUP and are cleared at the next accept edge.
- quotient/remainder hold their last values through IDLE and DIVIDE. They change only at FIXUP or reset.

Test Plan:
- WIDTH=8, unsigned 100/7 -> ready exactly 9 edges after accept, quotient=14 (0x0E), remainder=2, flags 0, busy high 9 cycles.
- Signed -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1). Signed 7/-2 -> quotient=0xFD, remainder=0x01.
- Signed 0x80/0xFF -> quotient=0x80, remainder=0x00, overflow=1. Same operands unsigned -> quotient=0x00, remainder=0x80, overflow=0.
- 25/0 (either mode) -> quotient=0xFF, remainder=0x19, div_by_zero=1, same latency as normal.
- start pulsed again mid-DIVIDE with new operands -> ignored, original result returned. Start held high during the ready cycle -> second operation accepted, its ready follows 9 edges later.
- rst=1 at step 4 of a division -> next cycle all outputs 0, state IDLE, no ready. New start 1 cycle after rst release -> correct result with normal latency.
